// File: rtl/handshake_constant_arbiter_pkg.sv
// Shared helpers for the handshake constant units: tag-width sizing and
// constant-table slicing.
package handshake_constant_arbiter_pkg;

  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxTableBits = 4096;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Entry idx of a packed table of width-bit constants; bits above width are zero.
  function automatic logic [MaxDataWidth-1:0] const_entry(input logic [MaxTableBits-1:0] tbl,
                                                          input int unsigned idx,
                                                          input int unsigned width);
    logic [MaxTableBits-1:0] shifted;
    logic [MaxDataWidth-1:0] mask;
    shifted = tbl >> (idx * width);
    mask = (width >= MaxDataWidth) ? '1 : ((MaxDataWidth'(1) << width) - MaxDataWidth'(1));
    return shifted[MaxDataWidth-1:0] & mask;
  endfunction

endpackage

// File: rtl/handshake_constant_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
  import handshake_constant_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned TAG_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [TAG_WIDTH-1:0] ptr,
  input  logic                 enable,
  output logic [NUM_REQ-1:0]   grant,
  output logic [TAG_WIDTH-1:0] grant_idx
);

  logic                 found;
  logic [TAG_WIDTH-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = TAG_WIDTH'((32'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/handshake_constant_arbiter.sv
// Round-robin sharing of one registered constant-output slot among NUM_REQ
// control requesters; each grant emits that requester's table constant and tag.
module handshake_constant_arbiter
  import handshake_constant_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE = '0,
  localparam int unsigned TAG_WIDTH = clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ins_valid,
  output logic [NUM_REQ-1:0]    ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [TAG_WIDTH-1:0]  outs_tag,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic [DATA_WIDTH-1:0] entry [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_entry
    logic [MaxDataWidth-1:0] full;
    assign full     = const_entry(MaxTableBits'(CONST_TABLE), i, DATA_WIDTH);
    assign entry[i] = full[DATA_WIDTH-1:0];
  end

  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  ptr_q, ptr_d;

  logic                  slot_free;
  logic [NUM_REQ-1:0]    grant;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic                  any_grant;

  assign slot_free = !valid_q || outs_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (ins_valid),
    .ptr       (ptr_q),
    .enable    (slot_free),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_grant = |grant;
  assign ins_ready = grant;

  always_comb begin
    outs_d  = outs_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (any_grant) begin
      // Drain and fill in the same cycle: a grant implies the slot is free.
      outs_d  = entry[grant_idx];
      tag_d   = grant_idx;
      valid_d = 1'b1;
      ptr_d   = (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
    end else if (outs_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      outs_q  <= outs_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign outs       = outs_q;
  assign outs_tag   = tag_q;
  assign outs_valid = valid_q;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed bench for handshake_constant_arbiter: NUM_REQ=4, 22-bit constants 0x0A..0x0D.
module tb_handshake_constant_arbiter;

  localparam int unsigned DW = 22;
  localparam int unsigned NR = 4;
  localparam logic [NR*DW-1:0] TBL = {22'h0D, 22'h0C, 22'h0B, 22'h0A};

  logic          clk;
  logic          rst;
  logic [NR-1:0] ins_valid;
  logic [NR-1:0] ins_ready;
  logic [DW-1:0] outs;
  logic [1:0]    outs_tag;
  logic          outs_valid;
  logic          outs_ready;

  int vectors;
  int miscompares;

  handshake_constant_arbiter #(
    .DATA_WIDTH  (DW),
    .NUM_REQ     (NR),
    .CONST_TABLE (TBL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_tag   (outs_tag),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [21:0] val, input logic [1:0] t,
                           input logic v);
    check({tag, ".outs"}, 32'(outs), 32'(val));
    check({tag, ".tag"}, 32'(outs_tag), 32'(t));
    check({tag, ".valid"}, 32'(outs_valid), 32'(v));
  endtask

  initial begin
    logic [3:0] exp_tag [6];
    logic [21:0] exp_val [4];
    exp_tag = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_val = '{22'h0A, 22'h0B, 22'h0C, 22'h0D};
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    ins_valid = '0;
    outs_ready = 1'b0;

    #12;
    check_out("reset", 22'h0, 2'd0, 1'b0);
    check("reset.ins_ready", 32'(ins_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 2
    ins_valid = 4'b0100;
    outs_ready = 1'b1;
    #1;
    check("single.ins_ready", 32'(ins_ready), 32'h4);
    tick();
    ins_valid = 4'b0000;
    check_out("single", 22'h0C, 2'd2, 1'b1);
    // ptr now 3: with everyone requesting, requester 3 wins
    ins_valid = 4'b1111;
    #1;
    check("ptr3.ins_ready", 32'(ins_ready), 32'h8);
    tick();
    ins_valid = 4'b0000;
    check_out("ptr3", 22'h0D, 2'd3, 1'b1);
    tick();
    check("drain.valid", 32'(outs_valid), 32'h0);

    // Continuous streaming, ptr back at 0
    ins_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("stream.ins_ready", 32'(ins_ready), 32'(4'b0001 << exp_tag[i]));
      tick();
      check_out("stream", exp_val[exp_tag[i]], exp_tag[i][1:0], 1'b1);
    end

    // Backpressure while FULL with tag 1
    outs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.ins_ready", 32'(ins_ready), 32'h0);
      tick();
      check_out("bp.hold", 22'h0B, 2'd1, 1'b1);
    end
    outs_ready = 1'b1;
    #1;
    check("bp.release.ins_ready", 32'(ins_ready), 32'h4);
    tick();
    check_out("bp.release", 22'h0C, 2'd2, 1'b1);

    // Wrap and skip from ptr=3
    ins_valid = 4'b0011;
    #1;
    check("wrap.ins_ready", 32'(ins_ready), 32'h1);
    tick();
    check_out("wrap", 22'h0A, 2'd0, 1'b1);
    #1;
    check("skip.ins_ready", 32'(ins_ready), 32'h2);
    tick();
    check_out("skip", 22'h0B, 2'd1, 1'b1);

    // Idle hold: grant 2, idle 5 cycles, then requester 3 wins
    ins_valid = 4'b0100;
    #1;
    check("idle.grant2", 32'(ins_ready), 32'h4);
    tick();
    check_out("idle.load", 22'h0C, 2'd2, 1'b1);
    ins_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle.ins_ready", 32'(ins_ready), 32'h0);
    end
    check_out("idle.hold", 22'h0C, 2'd2, 1'b0);
    ins_valid = 4'b1111;
    #1;
    check("idle.resume.ins_ready", 32'(ins_ready), 32'h8);
    tick();
    check_out("idle.resume", 22'h0D, 2'd3, 1'b1);

    // Async reset while FULL
    ins_valid = 4'b0000;
    outs_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 22'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    outs_ready = 1'b1;
    ins_valid = 4'b1110;
    #1;
    check("post_rst.ins_ready", 32'(ins_ready), 32'h2);
    tick();
    check_out("post_rst", 22'h0B, 2'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
